// File: rtl/lsu_sram_port_pkg.sv
// Shared types and constants for the load/store unit SRAM port.
package lsu_sram_port_pkg;

  localparam int WORD_W             = 32;
  localparam int SRAM_READ_LATENCY  = 2;
  localparam int SRAM_ADDR_WIDTH    = 11;
  localparam int LSU_CNT_W          = $clog2(SRAM_READ_LATENCY + 1);

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_load_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } funct3_store_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_t;

  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    if (store) return (f3 > 3'b010);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_sram_port_if.sv
// Request/response and SRAM bus bundle for the load/store unit.
interface lsu_sram_port_if
  import lsu_sram_port_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_WIDTH
);
  // Request transfers on a cycle where req_valid && req_ready; the LSU holds
  // req_ready low until its one-cycle resp_valid pulse, which has no backpressure.
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [WORD_W-1:0] sram_din;
  logic [WORD_W-1:0] sram_dout;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, sram_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           sram_en, sram_we, sram_addr, sram_din
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, sram_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           sram_en, sram_we, sram_addr, sram_din
  );
endinterface

// File: rtl/lsu_sram_port_mem_align.sv
// Byte/half lane extraction for loads and read-modify-write merge for stores.
// Misalignment is only flagged when LSU_MISALIGN_TRAP_EN is defined.
module lsu_sram_port_mem_align
  import lsu_sram_port_pkg::*;
(
  input  logic              store,
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] rdbuf,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] store_word,
  output logic              misaligned
);
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    byte_sh = {offset, 3'b000};
    half_sh = {offset[1], 4'b0000};
    rd_byte = 8'(rdbuf >> byte_sh);
    rd_half = 16'(rdbuf >> half_sh);

    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      F3_LW:   load_data = rdbuf;
      F3_LBU:  load_data = {24'b0, rd_byte};
      F3_LHU:  load_data = {16'b0, rd_half};
      default: load_data = '0;
    endcase

    store_word = wdata;
    case (funct3)
      F3_SB:   store_word = (rdbuf & ~(32'h0000_00FF << byte_sh)) |
                            (WORD_W'(wdata[7:0]) << byte_sh);
      F3_SH:   store_word = (rdbuf & ~(32'h0000_FFFF << half_sh)) |
                            (WORD_W'(wdata[15:0]) << half_sh);
      default: store_word = wdata;
    endcase

    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (store)
      misaligned = ((funct3 == F3_SH) && offset[0]) ||
                   ((funct3 == F3_SW) && (offset != 2'b00));
    else
      misaligned = (((funct3 == F3_LH) || (funct3 == F3_LHU)) && offset[0]) ||
                   ((funct3 == F3_LW) && (offset != 2'b00));
`endif
  end
endmodule

// File: rtl/lsu_sram_port.sv
// RV32I load/store unit driving a word-wide SRAM without byte enables.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu_sram_port
  import lsu_sram_port_pkg::*;
#(
  parameter int READ_LATENCY = SRAM_READ_LATENCY,
  parameter int ADDR_W       = SRAM_ADDR_WIDTH
)(
  input  logic                CLK,
  input  logic                nRST,
  lsu_sram_port_if.master     bus,
  output lsu_state_t          dbg_state
);
  lsu_state_t           state_q, state_d;
  logic [LSU_CNT_W-1:0] cnt_q;
  logic [ADDR_W+1:0]    addr_q;
  logic [2:0]           f3_q;
  logic [WORD_W-1:0]    wdata_q;
  logic                 store_q;
  logic                 err_q;
  logic [WORD_W-1:0]    rdbuf_q;

  logic                 idle, active, last_wait, req_err, misaligned;
  logic                 al_store;
  logic [2:0]           al_f3;
  logic [1:0]           al_off;
  logic [WORD_W-1:0]    load_data, store_word;

  assign idle      = (state_q == IDLE);
  assign active    = (state_q == RD) || (state_q == WAIT) || (state_q == WR);
  assign last_wait = (cnt_q == LSU_CNT_W'(READ_LATENCY - 1));

  // In IDLE the aligner looks at the incoming request so the error decision
  // is ready at accept; afterwards it works on the captured request.
  assign al_store = idle ? bus.req_store       : store_q;
  assign al_f3    = idle ? bus.req_funct3      : f3_q;
  assign al_off   = idle ? bus.req_addr[1:0]   : addr_q[1:0];
  assign req_err  = f3_illegal(bus.req_store, bus.req_funct3) | misaligned;

  lsu_sram_port_mem_align u_align (
    .store      (al_store),
    .funct3     (al_f3),
    .offset     (al_off),
    .rdbuf      (rdbuf_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word),
    .misaligned (misaligned)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (req_err)                                        state_d = RESP;
        else if (bus.req_store && bus.req_funct3 == F3_SW)  state_d = WR;
        else                                                state_d = RD;
      end
      RD:      state_d = WAIT;
      WAIT:    if (last_wait) state_d = store_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      rdbuf_q <= '0;
    end else begin
      if (idle && bus.req_valid) begin
        addr_q  <= bus.req_addr[ADDR_W+1:0];
        f3_q    <= bus.req_funct3;
        wdata_q <= bus.req_wdata;
        store_q <= bus.req_store;
        err_q   <= req_err;
      end
      if (state_q == RD)        cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
      if (state_q == WAIT && last_wait) rdbuf_q <= bus.sram_dout;
    end
  end

  always_comb begin
    bus.req_ready  = idle;
    bus.sram_en    = (state_q == RD) || (state_q == WR);
    bus.sram_we    = (state_q == WR);
    bus.sram_addr  = active ? addr_q[ADDR_W+1:2] : '0;
    bus.sram_din   = (active && store_q) ? store_word : '0;
    bus.resp_valid = (state_q == RESP);
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.resp_rdata = ((state_q == RESP) && !err_q && !store_q) ? load_data : '0;
  end

  assign dbg_state = state_q;
endmodule

// File: tb/tb_lsu_sram_port.sv
// Directed-vector bench for lsu_sram_port with a 2-cycle-latency SRAM model.
module tb_lsu_sram_port;
  import lsu_sram_port_pkg::*;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
    int          exp_we;
    logic [31:0] exp_din;
    logic [10:0] exp_saddr;
  } vec_t;

  logic        CLK;
  logic        nRST;
  lsu_state_t  dbg_state;
  lsu_sram_port_if bus ();

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs[$];

  logic [31:0] mem [2048];
  logic [31:0] rd_pipe;

  lsu_sram_port dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: read data appears two cycles after the enable cycle
  always @(posedge CLK) begin
    if (bus.sram_en && bus.sram_we) mem[bus.sram_addr] <= bus.sram_din;
    if (bus.sram_en && !bus.sram_we) rd_pipe <= mem[bus.sram_addr];
    bus.sram_dout <= rd_pipe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    int cyc, en_cnt, we_cnt;
    logic got, bad_addr;
    logic [31:0] din, rdata, exp_rd;
    logic err;
    cyc = 0; en_cnt = 0; we_cnt = 0; got = 0; bad_addr = 0;
    din = '0; rdata = '0; err = 0;
    @(negedge CLK);
    check("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_store  = v.store;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    exp_q.push_back(v.exp_rdata);
    @(posedge CLK);
    while (!got && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        bus.req_valid = 1'b0;
        check("ready_busy", 32'(bus.req_ready), 32'd0);
      end
      if (bus.sram_en) begin
        en_cnt++;
        if (bus.sram_addr !== v.exp_saddr) bad_addr = 1'b1;
      end
      if (bus.sram_we) begin
        we_cnt++;
        din = bus.sram_din;
      end
      if (bus.resp_valid) begin
        got   = 1'b1;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
      end
    end
    exp_rd = exp_q.pop_front();
    check("resp_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), 32'(v.exp_lat));
    check("rdata", rdata, exp_rd);
    check("err", 32'(err), 32'(v.exp_err));
    check("en_cycles", 32'(en_cnt), 32'(v.exp_en));
    check("we_pulses", 32'(we_cnt), 32'(v.exp_we));
    check("sram_addr", 32'(bad_addr), 32'd0);
    if (we_cnt > 0) check("sram_din", din, v.exp_din);
  endtask

  initial begin
    int we_seen;
    bus.req_valid = 0; bus.req_store = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.sram_dout = 0;
    rd_pipe = 0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;

    //          st f3      addr          wdata         rdata         err lat en we din           saddr
    vecs.push_back('{1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2, 1, 1, 32'hDEADBEEF, 11'h4});
    vecs.push_back('{0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0, 4, 1, 0, 32'h0,        11'h4});
    vecs.push_back('{1, 3'b010, 32'h10,   32'h11223344, 32'h0,        0, 2, 1, 1, 32'h11223344, 11'h4});
    vecs.push_back('{1, 3'b000, 32'h13,   32'h12345680, 32'h0,        0, 5, 2, 1, 32'h80223344, 11'h4});
    vecs.push_back('{0, 3'b000, 32'h13,   32'h0,        32'hFFFFFF80, 0, 4, 1, 0, 32'h0,        11'h4});
    vecs.push_back('{0, 3'b100, 32'h13,   32'h0,        32'h00000080, 0, 4, 1, 0, 32'h0,        11'h4});
    vecs.push_back('{1, 3'b001, 32'h12,   32'hAAAABEEF, 32'h0,        0, 5, 2, 1, 32'hBEEF3344, 11'h4});
    vecs.push_back('{0, 3'b001, 32'h12,   32'h0,        32'hFFFFBEEF, 0, 4, 1, 0, 32'h0,        11'h4});
    vecs.push_back('{0, 3'b101, 32'h12,   32'h0,        32'h0000BEEF, 0, 4, 1, 0, 32'h0,        11'h4});
    vecs.push_back('{0, 3'b000, 32'h10,   32'h0,        32'h00000044, 0, 4, 1, 0, 32'h0,        11'h4});
    vecs.push_back('{0, 3'b011, 32'h0,    32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        11'h0});
    vecs.push_back('{1, 3'b101, 32'h10,   32'h12345678, 32'h0,        1, 1, 0, 0, 32'h0,        11'h4});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back('{0, 3'b010, 32'h11,   32'h0,        32'h0,        1, 1, 0, 0, 32'h0,        11'h4});
`else
    vecs.push_back('{0, 3'b010, 32'h11,   32'h0,        32'hBEEF3344, 0, 4, 1, 0, 32'h0,        11'h4});
`endif
    vecs.push_back('{1, 3'b010, 32'h2020, 32'h7F01A5C3, 32'h0,        0, 2, 1, 1, 32'h7F01A5C3, 11'h8});
    vecs.push_back('{0, 3'b010, 32'h20,   32'h0,        32'h7F01A5C3, 0, 4, 1, 0, 32'h0,        11'h8});
    vecs.push_back('{0, 3'b001, 32'h22,   32'h0,        32'h00007F01, 0, 4, 1, 0, 32'h0,        11'h8});
    vecs.push_back('{0, 3'b100, 32'h21,   32'h0,        32'h000000A5, 0, 4, 1, 0, 32'h0,        11'h8});
    vecs.push_back('{0, 3'b000, 32'h20,   32'h0,        32'hFFFFFFC3, 0, 4, 1, 0, 32'h0,        11'h8});
    vecs.push_back('{1, 3'b001, 32'h20,   32'h00008001, 32'h0,        0, 5, 2, 1, 32'h7F018001, 11'h8});
    vecs.push_back('{0, 3'b001, 32'h20,   32'h0,        32'hFFFF8001, 0, 4, 1, 0, 32'h0,        11'h8});

    // reset state
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_outs", {bus.sram_en, bus.sram_we, bus.resp_valid, bus.resp_err},
          32'd0);
    check("rst_bus", bus.resp_rdata | bus.sram_din | 32'(bus.sram_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    nRST = 1'b1;

    foreach (vecs[i]) do_op(vecs[i]);

    // reset while the RMW of a byte store is waiting for read data
    we_seen = 0;
    @(negedge CLK);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h000000AA;
    @(posedge CLK);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    if (bus.sram_we) we_seen++;
    @(negedge CLK);
    if (bus.sram_we) we_seen++;
    check("mid_state", 32'(dbg_state), 32'(WAIT));
    nRST = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_outs", {bus.sram_en, bus.sram_we, bus.resp_valid, bus.resp_err},
          32'd0);
    check("mid_rst_bus", bus.resp_rdata | bus.sram_din | 32'(bus.sram_addr), 32'd0);
    repeat (2) begin
      @(negedge CLK);
      if (bus.sram_we) we_seen++;
    end
    nRST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (bus.sram_we) we_seen++;
    end
    check("mid_rst_no_write", 32'(we_seen), 32'd0);
    do_op('{0, 3'b010, 32'h10, 32'h0, 32'hBEEF3344, 0, 4, 1, 0, 32'h0, 11'h4});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
